ahb_lite_arbiter_2x1: RTL and testbench
=======================================

# ahb_lite_arbiter_2x1

Two-master to one-master AHB-Lite arbiter that lets the CPU and a second bus master share the single master port of the AHB-Lite interconnect.

- Round-robin grant; the bus is re-arbitrated only at transfer boundaries.
- A transfer that a requester issues while it does not own the bus is captured in a per-port buffer and replayed later. The requester is stalled until that transfer completes.
- Write data and responses pass through unregistered.

## Interface
- HADDR_WIDTH, 32, address width.
- HDATA_WIDTH, 32, data width.

Clock and reset:
- HCLK  input  1  bus clock; all state updates on the rising edge.
- HRESET  input  1  reset, asynchronous, active-high.

Requester side, index 0 = CPU, index 1 = second master:
- s_HADDR  input  [1:0][HADDR_WIDTH-1:0]  requester address.
- s_HBURST, s_HPROT, s_HSIZE  input  [1:0][2:0], [1:0][3:0], [1:0][2:0]  transfer attributes.
- s_HMASTLOCK, s_HWRITE  input  [1:0]  lock and write flags.
- s_HTRANS  input  [1:0][1:0]  transfer type.
- s_HWDATA  input  [1:0][HDATA_WIDTH-1:0]  write data, data phase.
- s_HRDATA  output  [1:0][HDATA_WIDTH-1:0]  both entries = m_HRDATA.
- s_HREADY  output  [1:0]  per-requester ready / stall.
- s_HRESP  output  [1:0]  per-requester response.

Interconnect side:
- m_HADDR, m_HBURST, m_HPROT, m_HSIZE, m_HMASTLOCK, m_HWRITE, m_HTRANS  output  same widths, single port  address phase of the selected requester.
- m_HWDATA  output  HDATA_WIDTH  write data of the data-phase owner.
- m_HRDATA  input  HDATA_WIDTH  read data.
- m_HREADY, m_HRESP  input  1  ready and response from the interconnect.

## Operation
Registers, with reset values:
- owner = 0
- last = 1, so port 0 wins the first tie
- locked = 0
- dphase = 0
- downer = 0
- pend_valid[1:0] = 0
- pend_* holds HADDR, HBURST, HPROT, HSIZE, HMASTLOCK, HWRITE, HTRANS per port.

Effective address phase:
- eff_i = pend_* of port i when pend_valid[i] is set; otherwise the live s_* of port i.
- req_i = eff_HTRANS_i[1], i.e. NONSEQ or SEQ.

Selection (combinational), sel:
- sel = owner if locked, or if owner's eff_HTRANS is SEQ or BUSY.
- Otherwise, if both ports request, sel = !last.
- Otherwise, if exactly one port requests, sel = that port.
- Otherwise sel = owner (bus parks on the owner).

Master outputs:
- m_* address-phase outputs = eff_sel.
- m_HWDATA = s_HWDATA[downer].

On each edge with m_HREADY = 1:
- owner <= sel.
- If req_sel:
  - dphase <= 1, downer <= sel, last <= sel.
  - locked <= eff_HMASTLOCK_sel.
  - pend_valid[sel] <= 0.
- Otherwise: dphase <= 0 and locked <= 0.

Capture:
- On any edge where s_HREADY[i] = 1 and s_HTRANS[i][1] = 1, the live request of port i is written into pend_*[i] and pend_valid[i] <= 1.
- Exception: no capture when the transfer is accepted directly, i.e. m_HREADY = 1, sel = i and pend_valid[i] = 0.

Requester ready and response:
- If dphase and downer = i: s_HREADY[i] = m_HREADY and s_HRESP[i] = m_HRESP.
- Else if pend_valid[i]: s_HREADY[i] = 0 and s_HRESP[i] = 0.
- Else: s_HREADY[i] = 1 and s_HRESP[i] = 0.

Invariants:
- A port never has pend_valid set while it is downer with dphase set.
- At most one buffered transfer per port.
- The requester holds s_HWDATA stable while stalled, so write data is not buffered.
- An ERROR response (two cycles, HRESP = 1) is forwarded unchanged to the data-phase owner. A pending transfer of the erroring master is still issued.

## Timing
Outputs in reset (HRESET high):
- s_HREADY = 2'b11, s_HRESP = 0.
- m_HTRANS = IDLE, with m_* = live port-0 signals.
- Assertion mid-transfer drops all pending transfers and data-phase tracking immediately.

Latency:
- Uncontended transfer: zero added cycles; address and data phases pass straight through.
- Losing requester: the buffered transfer is issued on the first edge where its address phase wins. Its data phase then completes normally.
- Added stall = the remaining length of the winner's transfer or burst, plus one arbitration cycle.

Handshake and grant rules:
- Grant never changes during a locked sequence or while owner presents SEQ or BUSY.
- Grant changes only when m_HREADY = 1.

Simultaneous NONSEQ on both ports with no history:
- Port 0 is selected, port 1 is captured.
- On the next accepting edge port 1 is selected, even if port 0 requests again.

## Test plan
1. **Single requester:** port 0 alone does a single read from 0xBFC00000 with zero-wait slave. Required: m_HADDR = 0xBFC00000 in the same cycle; s_HRDATA[0] valid one cycle later; s_HREADY[1] stays 1.
2. **Simultaneous requests:** both ports issue NONSEQ writes on the same edge (0x80000000 from port 0, 0x80000010 from port 1). Required:
   - Port 0 goes first.
   - pend_valid[1] = 1 and s_HREADY[1] = 0.
   - Port 1's address appears on m_HADDR the next cycle, with m_HWDATA = s_HWDATA[1] in its data phase.
   - s_HREADY[1] rises when that data phase completes.
3. **Burst protection:** port 1 runs an INCR4 from 0x80000100 while port 0 requests mid-burst. Required: all four beats complete uninterrupted; port 0 is granted on the cycle after the last SEQ.
4. **Locked sequence:** port 0 does a locked read then write with HMASTLOCK = 1 while port 1 requests. Required: port 1 is held off until port 0's locked write is accepted and HMASTLOCK returns to 0.
5. **Slave wait and error:** slave inserts 3 wait states and then an ERROR on port 1's buffered transfer. Required: s_HREADY[1] = 0 for the whole stall; s_HRESP[1] = 1 for both ERROR cycles; s_HRESP[0] = 0 throughout.
6. **Mid-transfer reset:** assert HRESET while pend_valid[1] = 1. Required: immediately s_HREADY = 2'b11, m_HTRANS = IDLE, and no stale transfer after reset is released.

Source files
------------

// File: rtl/ahb_lite_arbiter_2x1.sv
// ahb_lite_arbiter_2x1
// Shares one AHB-Lite master port between two requesters (0 = CPU, 1 = second
// master). Round-robin grant, re-arbitrated only at transfer boundaries. A
// transfer issued while the requester does not own the bus is captured in a
// one-deep per-port buffer and replayed later; the requester is stalled until
// that replayed transfer completes. Write data and responses pass through.
module ahb_lite_arbiter_2x1 #(
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  // requester side
  input  logic [1:0][HADDR_WIDTH-1:0] s_HADDR,
  input  logic [1:0][2:0]             s_HBURST,
  input  logic [1:0][3:0]             s_HPROT,
  input  logic [1:0][2:0]             s_HSIZE,
  input  logic [1:0]                  s_HMASTLOCK,
  input  logic [1:0]                  s_HWRITE,
  input  logic [1:0][1:0]             s_HTRANS,
  input  logic [1:0][HDATA_WIDTH-1:0] s_HWDATA,
  output logic [1:0][HDATA_WIDTH-1:0] s_HRDATA,
  output logic [1:0]                  s_HREADY,
  output logic [1:0]                  s_HRESP,
  // interconnect side
  output logic [HADDR_WIDTH-1:0]      m_HADDR,
  output logic [2:0]                  m_HBURST,
  output logic [3:0]                  m_HPROT,
  output logic [2:0]                  m_HSIZE,
  output logic                        m_HMASTLOCK,
  output logic                        m_HWRITE,
  output logic [1:0]                  m_HTRANS,
  output logic [HDATA_WIDTH-1:0]      m_HWDATA,
  input  logic [HDATA_WIDTH-1:0]      m_HRDATA,
  input  logic                        m_HREADY,
  input  logic                        m_HRESP
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  // arbitration state
  logic r_owner;
  logic r_last;
  logic r_locked;
  logic r_dphase;
  logic r_downer;

  // per-port replay buffer
  logic [1:0]                  r_pend_valid;
  logic [1:0][HADDR_WIDTH-1:0] r_pend_haddr;
  logic [1:0][2:0]             r_pend_hburst;
  logic [1:0][3:0]             r_pend_hprot;
  logic [1:0][2:0]             r_pend_hsize;
  logic [1:0]                  r_pend_hmastlock;
  logic [1:0]                  r_pend_hwrite;
  logic [1:0][1:0]             r_pend_htrans;

  // effective address phase per port (buffered request takes precedence)
  logic [1:0][HADDR_WIDTH-1:0] w_eff_haddr;
  logic [1:0][2:0]             w_eff_hburst;
  logic [1:0][3:0]             w_eff_hprot;
  logic [1:0][2:0]             w_eff_hsize;
  logic [1:0]                  w_eff_hmastlock;
  logic [1:0]                  w_eff_hwrite;
  logic [1:0][1:0]             w_eff_htrans;
  logic [1:0]                  w_req;
  logic                        w_sel;
  logic                        w_accept;
  logic [1:0]                  w_capture;
  logic [1:0]                  w_grant_clr;

  // Pick the buffered request of a port when present, else its live request.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (r_pend_valid[i]) begin
        w_eff_haddr[i]     = r_pend_haddr[i];
        w_eff_hburst[i]    = r_pend_hburst[i];
        w_eff_hprot[i]     = r_pend_hprot[i];
        w_eff_hsize[i]     = r_pend_hsize[i];
        w_eff_hmastlock[i] = r_pend_hmastlock[i];
        w_eff_hwrite[i]    = r_pend_hwrite[i];
        w_eff_htrans[i]    = r_pend_htrans[i];
      end else begin
        w_eff_haddr[i]     = s_HADDR[i];
        w_eff_hburst[i]    = s_HBURST[i];
        w_eff_hprot[i]     = s_HPROT[i];
        w_eff_hsize[i]     = s_HSIZE[i];
        w_eff_hmastlock[i] = s_HMASTLOCK[i];
        w_eff_hwrite[i]    = s_HWRITE[i];
        w_eff_htrans[i]    = s_HTRANS[i];
      end
      w_req[i] = w_eff_htrans[i][1];
    end
  end

  // Grant selection: hold during locks and bursts (SEQ/BUSY has bit 0 set),
  // alternate on contention, otherwise follow the sole requester or park.
  always_comb begin
    w_sel = r_owner;
    if (r_locked || w_eff_htrans[r_owner][0]) begin
      w_sel = r_owner;
    end else if (w_req[0] && w_req[1]) begin
      w_sel = ~r_last;
    end else if (w_req[0]) begin
      w_sel = 1'b0;
    end else if (w_req[1]) begin
      w_sel = 1'b1;
    end else begin
      w_sel = r_owner;
    end
  end

  assign w_accept = m_HREADY & w_req[w_sel];

  // Per-port capture and grant-clear strobes for the replay buffer.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_grant_clr[i] = w_accept & (w_sel == i[0]);
      w_capture[i]   = s_HREADY[i] & s_HTRANS[i][1]
                     & ~(m_HREADY & (w_sel == i[0]) & ~r_pend_valid[i]);
    end
  end

  // Drive the interconnect address phase; in reset present idle port-0 signals.
  always_comb begin
    if (HRESET) begin
      m_HADDR     = s_HADDR[0];
      m_HBURST    = s_HBURST[0];
      m_HPROT     = s_HPROT[0];
      m_HSIZE     = s_HSIZE[0];
      m_HMASTLOCK = s_HMASTLOCK[0];
      m_HWRITE    = s_HWRITE[0];
      m_HTRANS    = HTRANS_IDLE;
    end else begin
      m_HADDR     = w_eff_haddr[w_sel];
      m_HBURST    = w_eff_hburst[w_sel];
      m_HPROT     = w_eff_hprot[w_sel];
      m_HSIZE     = w_eff_hsize[w_sel];
      m_HMASTLOCK = w_eff_hmastlock[w_sel];
      m_HWRITE    = w_eff_hwrite[w_sel];
      m_HTRANS    = w_eff_htrans[w_sel];
    end
  end

  assign m_HWDATA = s_HWDATA[r_downer];
  assign s_HRDATA = {m_HRDATA, m_HRDATA};

  // Per-requester ready/response: data-phase owner sees the slave, a port with
  // a buffered transfer is stalled, any other port sees an idle ready bus.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (HRESET) begin
        s_HREADY[i] = 1'b1;
        s_HRESP[i]  = 1'b0;
      end else if (r_dphase && (r_downer == i[0])) begin
        s_HREADY[i] = m_HREADY;
        s_HRESP[i]  = m_HRESP;
      end else if (r_pend_valid[i]) begin
        s_HREADY[i] = 1'b0;
        s_HRESP[i]  = 1'b0;
      end else begin
        s_HREADY[i] = 1'b1;
        s_HRESP[i]  = 1'b0;
      end
    end
  end

  // Arbitration state: ownership, round-robin history, lock and data-phase tracking.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_locked <= 1'b0;
      r_dphase <= 1'b0;
      r_downer <= 1'b0;
    end else if (m_HREADY) begin
      r_owner <= w_sel;
      if (w_req[w_sel]) begin
        r_dphase <= 1'b1;
        r_downer <= w_sel;
        r_last   <= w_sel;
        r_locked <= w_eff_hmastlock[w_sel];
      end else begin
        r_dphase <= 1'b0;
        r_locked <= 1'b0;
      end
    end
  end

  // Replay buffer: clear when the buffered transfer is issued, load when a
  // ready requester issues a transfer that is not taken directly.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_pend_valid     <= 2'b00;
      r_pend_haddr     <= '0;
      r_pend_hburst    <= '0;
      r_pend_hprot     <= '0;
      r_pend_hsize     <= '0;
      r_pend_hmastlock <= 2'b00;
      r_pend_hwrite    <= 2'b00;
      r_pend_htrans    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_capture[i]) begin
          r_pend_valid[i]     <= 1'b1;
          r_pend_haddr[i]     <= s_HADDR[i];
          r_pend_hburst[i]    <= s_HBURST[i];
          r_pend_hprot[i]     <= s_HPROT[i];
          r_pend_hsize[i]     <= s_HSIZE[i];
          r_pend_hmastlock[i] <= s_HMASTLOCK[i];
          r_pend_hwrite[i]    <= s_HWRITE[i];
          r_pend_htrans[i]    <= s_HTRANS[i];
        end else if (w_grant_clr[i]) begin
          r_pend_valid[i] <= 1'b0;
        end else begin
          r_pend_valid[i] <= r_pend_valid[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_arbiter_2x1.sv
// Directed bench for ahb_lite_arbiter_2x1: inputs change 1ns after the rising
// edge, outputs are sampled 3ns later, well before the next edge.
module tb_ahb_lite_arbiter_2x1;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic [1:0][31:0]  s_HADDR;
  logic [1:0][2:0]   s_HBURST;
  logic [1:0][3:0]   s_HPROT;
  logic [1:0][2:0]   s_HSIZE;
  logic [1:0]        s_HMASTLOCK;
  logic [1:0]        s_HWRITE;
  logic [1:0][1:0]   s_HTRANS;
  logic [1:0][31:0]  s_HWDATA;
  logic [1:0][31:0]  s_HRDATA;
  logic [1:0]        s_HREADY;
  logic [1:0]        s_HRESP;
  logic [31:0]       m_HADDR;
  logic [2:0]        m_HBURST;
  logic [3:0]        m_HPROT;
  logic [2:0]        m_HSIZE;
  logic              m_HMASTLOCK;
  logic              m_HWRITE;
  logic [1:0]        m_HTRANS;
  logic [31:0]       m_HWDATA;
  logic [31:0]       m_HRDATA;
  logic              m_HREADY;
  logic              m_HRESP;

  int n_chk  = 0;
  int n_fail = 0;

  ahb_lite_arbiter_2x1 #(.HADDR_WIDTH(32), .HDATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .s_HADDR(s_HADDR), .s_HBURST(s_HBURST), .s_HPROT(s_HPROT), .s_HSIZE(s_HSIZE),
    .s_HMASTLOCK(s_HMASTLOCK), .s_HWRITE(s_HWRITE), .s_HTRANS(s_HTRANS),
    .s_HWDATA(s_HWDATA), .s_HRDATA(s_HRDATA), .s_HREADY(s_HREADY), .s_HRESP(s_HRESP),
    .m_HADDR(m_HADDR), .m_HBURST(m_HBURST), .m_HPROT(m_HPROT), .m_HSIZE(m_HSIZE),
    .m_HMASTLOCK(m_HMASTLOCK), .m_HWRITE(m_HWRITE), .m_HTRANS(m_HTRANS),
    .m_HWDATA(m_HWDATA), .m_HRDATA(m_HRDATA), .m_HREADY(m_HREADY), .m_HRESP(m_HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive(input int p, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic lk, input logic [2:0] bu);
    s_HTRANS[p]    = tr;
    s_HADDR[p]     = a;
    s_HWRITE[p]    = wr;
    s_HMASTLOCK[p] = lk;
    s_HBURST[p]    = bu;
    s_HSIZE[p]     = 3'd2;
    s_HPROT[p]     = 4'h3;
  endtask

  task automatic all_idle();
    drive(0, IDLE, 32'h0, 1'b0, 1'b0, 3'd0);
    drive(1, IDLE, 32'h0, 1'b0, 1'b0, 3'd0);
    s_HWDATA = '0;
    m_HRDATA = 32'h0;
    m_HREADY = 1'b1;
    m_HRESP  = 1'b0;
  endtask

  task automatic do_reset();
    all_idle();
    HRESET = 1'b1;
    step(); step();
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    all_idle();
    HRESET = 1'b1;
    drive(0, NSEQ, 32'h1111_2220, 1'b1, 1'b0, 3'd0);
    drive(1, NSEQ, 32'h3333_4440, 1'b0, 1'b0, 3'd0);
    settle();
    n_chk++; if (s_HREADY !== 2'b11) begin n_fail++; $display("FAIL rst_hready: got %b exp 11", s_HREADY); end
    n_chk++; if (s_HRESP !== 2'b00) begin n_fail++; $display("FAIL rst_hresp: got %b exp 00", s_HRESP); end
    n_chk++; if (m_HTRANS !== IDLE) begin n_fail++; $display("FAIL rst_htrans: got %b exp 00", m_HTRANS); end
    n_chk++; if (m_HADDR !== 32'h1111_2220) begin n_fail++; $display("FAIL rst_haddr: got %h exp 11112220", m_HADDR); end
    step();
    HRESET = 1'b0;
    all_idle();
  endtask

  task automatic test_single();
    do_reset();
    drive(0, NSEQ, 32'hBFC0_0000, 1'b0, 1'b0, 3'd0);
    settle();
    n_chk++; if (m_HADDR !== 32'hBFC0_0000) begin n_fail++; $display("FAIL single_addr: got %h exp bfc00000", m_HADDR); end
    n_chk++; if (m_HTRANS !== NSEQ) begin n_fail++; $display("FAIL single_trans: got %b exp 10", m_HTRANS); end
    n_chk++; if (s_HREADY !== 2'b11) begin n_fail++; $display("FAIL single_rdy_a: got %b exp 11", s_HREADY); end
    step();
    drive(0, IDLE, 32'h0, 1'b0, 1'b0, 3'd0);
    m_HRDATA = 32'hCAFE_0001;
    settle();
    n_chk++; if (s_HRDATA[0] !== 32'hCAFE_0001) begin n_fail++; $display("FAIL single_rdata: got %h exp cafe0001", s_HRDATA[0]); end
    n_chk++; if (s_HREADY !== 2'b11) begin n_fail++; $display("FAIL single_rdy_d: got %b exp 11", s_HREADY); end
    n_chk++; if (m_HTRANS !== IDLE) begin n_fail++; $display("FAIL single_idle: got %b exp 00", m_HTRANS); end
    step();
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(0, NSEQ, 32'h8000_0000, 1'b1, 1'b0, 3'd0);
    drive(1, NSEQ, 32'h8000_0010, 1'b1, 1'b0, 3'd0);
    settle();
    n_chk++; if (m_HADDR !== 32'h8000_0000) begin n_fail++; $display("FAIL sim_first: got %h exp 80000000", m_HADDR); end
    step();
    drive(0, IDLE, 32'h0, 1'b0, 1'b0, 3'd0);
    s_HWDATA[0] = 32'hD000_0000;
    s_HWDATA[1] = 32'hD111_1111;
    settle();
    n_chk++; if (dut.r_pend_valid[1] !== 1'b1) begin n_fail++; $display("FAIL sim_pend1: got %b exp 1", dut.r_pend_valid[1]); end
    n_chk++; if (s_HREADY[1] !== 1'b0) begin n_fail++; $display("FAIL sim_stall1: got %b exp 0", s_HREADY[1]); end
    n_chk++; if (m_HADDR !== 32'h8000_0010) begin n_fail++; $display("FAIL sim_second: got %h exp 80000010", m_HADDR); end
    n_chk++; if (m_HWDATA !== 32'hD000_0000) begin n_fail++; $display("FAIL sim_wdata0: got %h exp d0000000", m_HWDATA); end
    step();
    drive(1, IDLE, 32'h0, 1'b0, 1'b0, 3'd0);
    settle();
    n_chk++; if (m_HWDATA !== 32'hD111_1111) begin n_fail++; $display("FAIL sim_wdata1: got %h exp d1111111", m_HWDATA); end
    n_chk++; if (s_HREADY[1] !== 1'b1) begin n_fail++; $display("FAIL sim_rdy1: got %b exp 1", s_HREADY[1]); end
    step();
    // round-robin: both request again, port 1 went last, so port 0 wins
    drive(0, NSEQ, 32'h8000_0020, 1'b0, 1'b0, 3'd0);
    drive(1, NSEQ, 32'h8000_0030, 1'b0, 1'b0, 3'd0);
    settle();
    n_chk++; if (m_HADDR !== 32'h8000_0020) begin n_fail++; $display("FAIL sim_rr: got %h exp 80000020", m_HADDR); end
    step();
    // port 1 buffered; port 0 requests again but port 1 must be selected
    drive(0, NSEQ, 32'h8000_0040, 1'b0, 1'b0, 3'd0);
    settle();
    n_chk++; if (m_HADDR !== 32'h8000_0030) begin n_fail++; $display("FAIL sim_rr2: got %h exp 80000030", m_HADDR); end
    step();
    all_idle();
    step(); step();
  endtask

  task automatic test_burst();
    do_reset();
    drive(1, NSEQ, 32'h8000_0100, 1'b0, 1'b0, 3'd3);
    settle();
    n_chk++; if (m_HADDR !== 32'h8000_0100 || m_HTRANS !== NSEQ) begin n_fail++; $display("FAIL burst_b0: got %h/%b exp 80000100/10", m_HADDR, m_HTRANS); end
    for (int b = 1; b < 4; b++) begin
      step();
      drive(1, SEQ, 32'h8000_0100 + 32'(4 * b), 1'b0, 1'b0, 3'd3);
      if (b == 1) drive(0, NSEQ, 32'h8000_0200, 1'b0, 1'b0, 3'd0);
      settle();
      n_chk++; if (m_HADDR !== 32'h8000_0100 + 32'(4 * b) || m_HTRANS !== SEQ) begin n_fail++; $display("FAIL burst_b%0d: got %h/%b exp %h/11", b, m_HADDR, m_HTRANS, 32'h8000_0100 + 32'(4 * b)); end
      if (b > 1) begin
        n_chk++; if (s_HREADY[0] !== 1'b0) begin n_fail++; $display("FAIL burst_stall0: got %b exp 0", s_HREADY[0]); end
      end
    end
    step();
    drive(1, IDLE, 32'h0, 1'b0, 1'b0, 3'd0);
    settle();
    n_chk++; if (m_HADDR !== 32'h8000_0200 || m_HTRANS !== NSEQ) begin n_fail++; $display("FAIL burst_grant0: got %h/%b exp 80000200/10", m_HADDR, m_HTRANS); end
    step();
    drive(0, IDLE, 32'h0, 1'b0, 1'b0, 3'd0);
    settle();
    n_chk++; if (s_HREADY[0] !== 1'b1) begin n_fail++; $display("FAIL burst_done0: got %b exp 1", s_HREADY[0]); end
    step();
  endtask

  task automatic test_locked();
    do_reset();
    drive(0, NSEQ, 32'h8000_0300, 1'b0, 1'b1, 3'd0);
    drive(1, NSEQ, 32'h8000_0400, 1'b1, 1'b0, 3'd0);
    settle();
    n_chk++; if (m_HADDR !== 32'h8000_0300 || m_HMASTLOCK !== 1'b1) begin n_fail++; $display("FAIL lock_rd: got %h/%b exp 80000300/1", m_HADDR, m_HMASTLOCK); end
    step();
    drive(0, NSEQ, 32'h8000_0304, 1'b1, 1'b1, 3'd0);
    settle();
    n_chk++; if (m_HADDR !== 32'h8000_0304) begin n_fail++; $display("FAIL lock_wr: got %h exp 80000304", m_HADDR); end
    n_chk++; if (s_HREADY[1] !== 1'b0) begin n_fail++; $display("FAIL lock_hold1a: got %b exp 0", s_HREADY[1]); end
    step();
    drive(0, IDLE, 32'h0, 1'b0, 1'b0, 3'd0);
    s_HWDATA[0] = 32'h0000_5A5A;
    settle();
    n_chk++; if (m_HTRANS !== IDLE || m_HMASTLOCK !== 1'b0) begin n_fail++; $display("FAIL lock_tail: got %b/%b exp 00/0", m_HTRANS, m_HMASTLOCK); end
    n_chk++; if (m_HWDATA !== 32'h0000_5A5A) begin n_fail++; $display("FAIL lock_wdata: got %h exp 00005a5a", m_HWDATA); end
    n_chk++; if (s_HREADY[1] !== 1'b0) begin n_fail++; $display("FAIL lock_hold1b: got %b exp 0", s_HREADY[1]); end
    step();
    settle();
    n_chk++; if (m_HADDR !== 32'h8000_0400 || m_HTRANS !== NSEQ) begin n_fail++; $display("FAIL lock_grant1: got %h/%b exp 80000400/10", m_HADDR, m_HTRANS); end
    step();
    drive(1, IDLE, 32'h0, 1'b0, 1'b0, 3'd0);
    settle();
    n_chk++; if (s_HREADY[1] !== 1'b1) begin n_fail++; $display("FAIL lock_done1: got %b exp 1", s_HREADY[1]); end
    step();
  endtask

  task automatic test_wait_error();
    do_reset();
    drive(0, NSEQ, 32'h8000_0500, 1'b0, 1'b0, 3'd0);
    drive(1, NSEQ, 32'h8000_0600, 1'b0, 1'b0, 3'd0);
    step();
    drive(0, IDLE, 32'h0, 1'b0, 1'b0, 3'd0);
    settle();
    n_chk++; if (m_HADDR !== 32'h8000_0600 || s_HREADY[1] !== 1'b0) begin n_fail++; $display("FAIL err_issue: got %h/%b exp 80000600/0", m_HADDR, s_HREADY[1]); end
    step();
    drive(1, IDLE, 32'h0, 1'b0, 1'b0, 3'd0);
    m_HREADY = 1'b0;
    for (int w = 0; w < 3; w++) begin
      settle();
      n_chk++; if (s_HREADY[1] !== 1'b0 || s_HRESP !== 2'b00) begin n_fail++; $display("FAIL err_wait%0d: got rdy1=%b resp=%b exp 0/00", w, s_HREADY[1], s_HRESP); end
      step();
    end
    m_HRESP = 1'b1;
    settle();
    n_chk++; if (s_HREADY[1] !== 1'b0 || s_HRESP !== 2'b10) begin n_fail++; $display("FAIL err_c1: got rdy1=%b resp=%b exp 0/10", s_HREADY[1], s_HRESP); end
    step();
    m_HREADY = 1'b1;
    settle();
    n_chk++; if (s_HREADY[1] !== 1'b1 || s_HRESP !== 2'b10) begin n_fail++; $display("FAIL err_c2: got rdy1=%b resp=%b exp 1/10", s_HREADY[1], s_HRESP); end
    step();
    m_HRESP = 1'b0;
    settle();
    n_chk++; if (s_HRESP !== 2'b00 || s_HREADY !== 2'b11) begin n_fail++; $display("FAIL err_after: got resp=%b rdy=%b exp 00/11", s_HRESP, s_HREADY); end
    step();
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(0, NSEQ, 32'h8000_0700, 1'b0, 1'b0, 3'd0);
    drive(1, NSEQ, 32'h8000_0800, 1'b0, 1'b0, 3'd0);
    step();
    drive(0, IDLE, 32'h0, 1'b0, 1'b0, 3'd0);
    settle();
    n_chk++; if (s_HREADY[1] !== 1'b0) begin n_fail++; $display("FAIL mrst_pend: got %b exp 0", s_HREADY[1]); end
    HRESET = 1'b1;
    #1;
    n_chk++; if (s_HREADY !== 2'b11) begin n_fail++; $display("FAIL mrst_hready: got %b exp 11", s_HREADY); end
    n_chk++; if (m_HTRANS !== IDLE) begin n_fail++; $display("FAIL mrst_htrans: got %b exp 00", m_HTRANS); end
    step();
    drive(1, IDLE, 32'h0, 1'b0, 1'b0, 3'd0);
    HRESET = 1'b0;
    settle();
    n_chk++; if (m_HTRANS !== IDLE || s_HREADY !== 2'b11) begin n_fail++; $display("FAIL mrst_stale: got %b/%b exp 00/11", m_HTRANS, s_HREADY); end
    step();
    settle();
    n_chk++; if (m_HTRANS !== IDLE || s_HREADY !== 2'b11) begin n_fail++; $display("FAIL mrst_stale2: got %b/%b exp 00/11", m_HTRANS, s_HREADY); end
    step();
  endtask

  initial begin
    HRESET = 1'b1;
    all_idle();
    test_reset();
    test_single();
    test_simultaneous();
    test_burst();
    test_locked();
    test_wait_error();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
